// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: request codes,
// FSM state encoding, coin values and the request priority encoder.
package change_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'b00,
        REQ_N    = 2'b01,
        REQ_D    = 2'b10,
        REQ_DD   = 2'b11
    } req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAN  = 3'd1,
        EJECT = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int NICKEL_CENTS = 5;
    localparam int DIME_CENTS   = 10;

    // Highest-value request wins when several return pulses coincide.
    function automatic req_t encode_req(input logic ret_n, input logic ret_d,
                                        input logic ret_dd);
        if (ret_dd) return REQ_DD;
        if (ret_d)  return REQ_D;
        if (ret_n)  return REQ_N;
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending machine / hopper hardware and the
// change dispenser. The master side drives requests and sensor pulses.
interface change_dispenser_if #(
    parameter int CNT_W = 6
) ();
    logic             Dispense;
    logic             ReturnNickel;
    logic             ReturnDime;
    logic             ReturnTwoDimes;
    logic             load_nickel;
    logic             load_dime;
    logic             coin_sensed;
    logic             product_release;
    logic             eject_nickel;
    logic             eject_dime;
    logic             busy;
    logic [CNT_W-1:0] nickel_count;
    logic [CNT_W-1:0] dime_count;
    logic             overflow;
    logic             fault;

    modport master (
        output Dispense, ReturnNickel, ReturnDime, ReturnTwoDimes,
               load_nickel, load_dime, coin_sensed,
        input  product_release, eject_nickel, eject_dime, busy,
               nickel_count, dime_count, overflow, fault
    );

    modport slave (
        input  Dispense, ReturnNickel, ReturnDime, ReturnTwoDimes,
               load_nickel, load_dime, coin_sensed,
        output product_release, eject_nickel, eject_dime, busy,
               nickel_count, dime_count, overflow, fault
    );
endinterface

// File: rtl/change_req_fifo.sv
// Synchronous FIFO holding pending change requests. Pushes into a full
// queue and pops from an empty queue are ignored; push and pop may coincide.
module change_req_fifo
    import change_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(QDEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    req_t        mem_q [QDEPTH];
    logic        do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted operations.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers define which
        // entries are valid, so stale contents are never observed.
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues return requests, plans dime/nickel mix against
// hopper inventory, and ejects one coin at a time with an exit-sensor
// handshake and jam timeout. Faults are sticky until reset.
module change_dispenser
    import change_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 6,
    parameter int NCAP   = 50,
    parameter int DCAP   = 50,
    parameter int TMO    = 200
) (
    input  logic                clk,
    input  logic                reset,
    change_dispenser_if.slave   bus
);
    state_t           state_q, state_d;
    req_t             req_q, req_d;
    logic [1:0]       d_need_q, d_need_d;
    logic [2:0]       n_need_q, n_need_d;
    logic [7:0]       timer_q, timer_d;
    logic             eject_nickel_q, eject_nickel_d;
    logic             eject_dime_q, eject_dime_d;
    logic [CNT_W-1:0] nickel_count_q, nickel_count_d;
    logic [CNT_W-1:0] dime_count_q, dime_count_d;
    logic             overflow_q, overflow_d;
    logic             fault_q, fault_d;
    logic             product_release_q, product_release_d;

    logic             push, pop, full, empty;
    req_t             push_data, pop_data;
    logic [CNT_W:0]   d_plan, n_plan;

    assign push_data = encode_req(bus.ReturnNickel, bus.ReturnDime, bus.ReturnTwoDimes);
    assign push      = (push_data != REQ_NONE);

    change_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty)
    );

    // Next-state logic for FSM, timer, needs, inventory and flags.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d           = state_q;
        req_d             = req_q;
        d_need_d          = d_need_q;
        n_need_d          = n_need_q;
        timer_d           = timer_q;
        eject_nickel_d    = 1'b0;
        eject_dime_d      = 1'b0;
        nickel_count_d    = nickel_count_q;
        dime_count_d      = dime_count_q;
        fault_d           = fault_q;
        overflow_d        = overflow_q | (push & full);
        product_release_d = bus.Dispense;
        pop               = 1'b0;
        d_plan            = '0;
        n_plan            = '0;

        case (state_q)
            IDLE: begin
                if (!empty && !fault_q) begin
                    pop     = 1'b1;
                    req_d   = pop_data;
                    state_d = PLAN;
                end
            end

            PLAN: begin
                case (req_q)
                    REQ_DD:  d_plan = (CNT_W+1)'(2);
                    REQ_D:   d_plan = (CNT_W+1)'(1);
                    default: n_plan = (CNT_W+1)'(1);
                endcase
                // Replace missing dimes with nickel pairs while nickels last.
                for (int i = 0; i < 2; i++) begin
                    if (d_plan > {1'b0, dime_count_q} &&
                        {1'b0, nickel_count_q} >= n_plan + (CNT_W+1)'(2)) begin
                        d_plan = d_plan - (CNT_W+1)'(1);
                        n_plan = n_plan + (CNT_W+1)'(2);
                    end
                end
                if (d_plan <= {1'b0, dime_count_q} && n_plan <= {1'b0, nickel_count_q}) begin
                    d_need_d       = d_plan[1:0];
                    n_need_d       = n_plan[2:0];
                    timer_d        = '0;
                    eject_dime_d   = (d_plan != '0);
                    eject_nickel_d = (d_plan == '0);
                    state_d        = EJECT;
                end else begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end
            end

            EJECT: begin
                if (bus.coin_sensed) begin
                    if (eject_dime_q) begin
                        d_need_d     = d_need_q - 2'd1;
                        dime_count_d = (dime_count_q != '0) ? dime_count_q - CNT_W'(1) : '0;
                    end else begin
                        n_need_d       = n_need_q - 3'd1;
                        nickel_count_d = (nickel_count_q != '0) ? nickel_count_q - CNT_W'(1) : '0;
                    end
                    state_d = GAP;
                end else if (timer_q == 8'(TMO - 1)) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else begin
                    eject_dime_d   = eject_dime_q;
                    eject_nickel_d = eject_nickel_q;
                    timer_d        = timer_q + 8'd1;
                end
            end

            GAP: begin
                if (d_need_q != '0 || n_need_q != '0) begin
                    timer_d        = '0;
                    eject_dime_d   = (d_need_q != '0);
                    eject_nickel_d = (d_need_q == '0);
                    state_d        = EJECT;
                end else begin
                    state_d = IDLE;
                end
            end

            FAULT: begin
                fault_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A refill overrides any decrement in the same cycle.
        if (bus.load_nickel) nickel_count_d = CNT_W'(NCAP);
        if (bus.load_dime)   dime_count_d   = CNT_W'(DCAP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            req_q             <= REQ_N;
            d_need_q          <= '0;
            n_need_q          <= '0;
            timer_q           <= '0;
            eject_nickel_q    <= 1'b0;
            eject_dime_q      <= 1'b0;
            nickel_count_q    <= '0;
            dime_count_q      <= '0;
            overflow_q        <= 1'b0;
            fault_q           <= 1'b0;
            product_release_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            d_need_q          <= d_need_d;
            n_need_q          <= n_need_d;
            timer_q           <= timer_d;
            eject_nickel_q    <= eject_nickel_d;
            eject_dime_q      <= eject_dime_d;
            nickel_count_q    <= nickel_count_d;
            dime_count_q      <= dime_count_d;
            overflow_q        <= overflow_d;
            fault_q           <= fault_d;
            product_release_q <= product_release_d;
        end
    end

    assign bus.product_release = product_release_q;
    assign bus.eject_nickel    = eject_nickel_q;
    assign bus.eject_dime      = eject_dime_q;
    assign bus.busy            = (state_q != IDLE) || !empty;
    assign bus.nickel_count    = nickel_count_q;
    assign bus.dime_count      = dime_count_q;
    assign bus.overflow        = overflow_q;
    assign bus.fault           = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: refills, plain and substituted change,
// insufficient coins, jam timeout, queue overflow, priority and reset.
module tb_change_dispenser;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 6;
    localparam int NCAP   = 50;
    localparam int DCAP   = 50;
    localparam int TMO    = 200;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    change_dispenser_if #(.CNT_W(CNT_W)) bus ();

    change_dispenser #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W),
        .NCAP   (NCAP),
        .DCAP   (DCAP),
        .TMO    (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_req(input logic n, input logic d, input logic dd);
        bus.ReturnNickel   = n;
        bus.ReturnDime     = d;
        bus.ReturnTwoDimes = dd;
        tick();
        bus.ReturnNickel   = 1'b0;
        bus.ReturnDime     = 1'b0;
        bus.ReturnTwoDimes = 1'b0;
    endtask

    task automatic load(input logic n, input logic d);
        bus.load_nickel = n;
        bus.load_dime   = d;
        tick();
        bus.load_nickel = 1'b0;
        bus.load_dime   = 1'b0;
    endtask

    // Acknowledge every ejected coin until the dispenser goes idle.
    task automatic serve_all(output int coins);
        coins = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.eject_nickel || bus.eject_dime) begin
                bus.coin_sensed = 1'b1;
                coins++;
            end
            tick();
            bus.coin_sensed = 1'b0;
            if (!bus.busy) break;
        end
        check("serve_done", bus.busy, 0);
    endtask

    function automatic logic [31:0] all_outputs();
        return {14'd0, bus.product_release, bus.eject_nickel, bus.eject_dime, bus.busy,
                bus.overflow, bus.fault, bus.nickel_count, bus.dime_count};
    endfunction

    initial begin
        int coins;
        logic seen;

        bus.Dispense       = 1'b0;
        bus.ReturnNickel   = 1'b0;
        bus.ReturnDime     = 1'b0;
        bus.ReturnTwoDimes = 1'b0;
        bus.load_nickel    = 1'b0;
        bus.load_dime      = 1'b0;
        bus.coin_sensed    = 1'b0;

        // 1: basic dime return
        do_reset();
        tick();
        check("reset_outputs", all_outputs(), 0);
        load(1'b1, 1'b1);
        check("load_nickel", bus.nickel_count, NCAP);
        check("load_dime", bus.dime_count, DCAP);
        bus.coin_sensed = 1'b1;
        tick();
        bus.coin_sensed = 1'b0;
        check("idle_sense_ignored", bus.dime_count, DCAP);
        pulse_req(1'b0, 1'b1, 1'b0);
        check("t1_busy_e0", bus.busy, 1);
        check("t1_no_eject_e0", bus.eject_dime, 0);
        tick();
        check("t1_no_eject_e1", bus.eject_dime, 0);
        tick();
        check("t1_eject_e2", bus.eject_dime, 1);
        check("t1_nickel_low", bus.eject_nickel, 0);
        bus.coin_sensed = 1'b1;
        tick();
        bus.coin_sensed = 1'b0;
        check("t1_gap_low", bus.eject_dime, 0);
        check("t1_dime_dec", bus.dime_count, DCAP - 1);
        check("t1_gap_busy", bus.busy, 1);
        tick();
        check("t1_idle", bus.busy, 0);

        // 2: two dimes substituted by four nickels
        do_reset();
        load(1'b1, 1'b0);
        pulse_req(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t2_eject_n", bus.eject_nickel, 1);
            check("t2_eject_d", bus.eject_dime, 0);
            bus.coin_sensed = 1'b1;
            tick();
            bus.coin_sensed = 1'b0;
            check("t2_gap", bus.eject_nickel, 0);
            tick();
            if (k == 3) check("t2_idle", bus.busy, 0);
        end
        check("t2_nickels", bus.nickel_count, NCAP - 4);
        check("t2_dimes", bus.dime_count, 0);
        check("t2_fault", bus.fault, 0);

        // 3: insufficient coins
        do_reset();
        load(1'b1, 1'b1);
        for (int k = 0; k < NCAP - 1; k++) begin
            pulse_req(1'b1, 1'b0, 1'b0);
            serve_all(coins);
            pulse_req(1'b0, 1'b1, 1'b0);
            serve_all(coins);
        end
        check("t3_pre_nickel", bus.nickel_count, 1);
        check("t3_pre_dime", bus.dime_count, 1);
        pulse_req(1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= bus.eject_nickel | bus.eject_dime;
        end
        check("t3_fault", bus.fault, 1);
        check("t3_no_eject", seen, 0);
        check("t3_nickel", bus.nickel_count, 1);
        check("t3_dime", bus.dime_count, 1);

        // 4: jam timeout
        do_reset();
        load(1'b1, 1'b0);
        pulse_req(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check("t4_eject", bus.eject_nickel, 1);
        repeat (TMO - 1) tick();
        check("t4_before_tmo_eject", bus.eject_nickel, 1);
        check("t4_before_tmo_fault", bus.fault, 0);
        tick();
        check("t4_tmo_fault", bus.fault, 1);
        check("t4_tmo_eject", bus.eject_nickel, 0);
        bus.Dispense = 1'b1;
        tick();
        bus.Dispense = 1'b0;
        check("t4_release_in_fault", bus.product_release, 1);
        pulse_req(1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= bus.eject_nickel | bus.eject_dime;
        end
        check("t4_frozen", seen, 0);
        check("t4_busy", bus.busy, 1);
        check("t4_count", bus.nickel_count, NCAP);

        // 5: queue overflow
        do_reset();
        load(1'b1, 1'b0);
        for (int k = 0; k < QDEPTH + 2; k++) pulse_req(1'b1, 1'b0, 1'b0);
        check("t5_overflow", bus.overflow, 1);
        check("t5_ejecting", bus.eject_nickel, 1);
        serve_all(coins);
        check("t5_coins", coins, QDEPTH + 1);
        check("t5_nickels", bus.nickel_count, NCAP - (QDEPTH + 1));
        check("t5_fault", bus.fault, 0);

        // 7: priority when several returns coincide
        do_reset();
        load(1'b1, 1'b1);
        pulse_req(1'b1, 1'b0, 1'b1);
        serve_all(coins);
        check("t7_coins", coins, 2);
        check("t7_dimes", bus.dime_count, DCAP - 2);
        check("t7_nickels", bus.nickel_count, NCAP);

        // 6: product release alongside change, then reset mid-eject
        do_reset();
        load(1'b0, 1'b1);
        bus.Dispense   = 1'b1;
        bus.ReturnDime = 1'b1;
        tick();
        bus.Dispense   = 1'b0;
        bus.ReturnDime = 1'b0;
        check("t6_release", bus.product_release, 1);
        tick();
        check("t6_release_done", bus.product_release, 0);
        tick();
        check("t6_eject", bus.eject_dime, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_reset_outputs", all_outputs(), 0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= bus.eject_nickel | bus.eject_dime | bus.busy;
        end
        check("t6_queue_empty", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
